reg_bank_wb: RTL and testbench

Write-back register bank for the multicycle datapath: 32 x 32-bit registers with one write port and two registered read ports. The write port is the receiving end of the registered write-data source mux, which presents its word one clock after the control unit issues the write. The block holds the write address for that cycle so address and data align, and commits the pair. Register 0 reads as zero; register 29 (stack pointer) resets to the same constant the source mux offers as its fixed value.

---
 rtl/reg_bank_wb.sv | 135 +++++++++++++
 tb/tb_reg_bank_wb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wb.sv
// ---------------------------------------------------------------------------
// reg_bank_wb
//
// Write-back register bank for the multicycle datapath: 2**ADDR_W registers
// of DATA_W bits. It has one write port and two registered read ports.
//
// The write port sits after the registered write-data source mux, so the data
// word arrives one clock after the control unit issues the write. The bank
// holds the write address for one cycle so that address and data line up,
// and then commits the pair.
//
// Write handshake (no back-pressure):
//   - reg_write=1 at an edge captures write_reg as the pending address.
//   - At the next edge, write_data is committed to that address.
//   - write_data is ignored in every cycle where no write is pending.
//   - A new capture may happen at the same edge as the previous commit,
//     which gives one write per cycle.
//
// Register 0 always reads as zero. Register SP_IDX resets to SP_RESET and
// is an ordinary writable register after reset.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a read of the address being committed at the same edge
//               returns write_data.
//   undefined : that read returns the pre-commit register value.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   reg_write   in   write request; write_reg is sampled in the same cycle
//   write_reg   in   [ADDR_W-1:0] destination register of the request
//   write_data  in   [DATA_W-1:0] write word, valid the cycle after reg_write
//   read_reg1   in   [ADDR_W-1:0] read port 1 address
//   read_reg2   in   [ADDR_W-1:0] read port 2 address
//   read_data1  out  [DATA_W-1:0] registered read port 1 data
//   read_data2  out  [DATA_W-1:0] registered read port 2 data
//   wb_pending  out  high while a captured write awaits commit
//   wb_done     out  one-cycle pulse after each commit
// ---------------------------------------------------------------------------
module reg_bank_wb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SP_IDX   = 29,
    parameter int unsigned SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              wb_pending,
    output logic              wb_done
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Pending-write stage: the address captured one edge before its data.
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;

    logic              commit_en;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    // Commits to register 0 are dropped, so regs[0] stays zero.
    // wb_done still pulses for them.
    assign commit_en  = pend_valid && (pend_addr != '0);
    assign wb_pending = pend_valid;

`ifdef WB_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = commit_en && (read_reg1 == pend_addr);
    assign hit2 = commit_en && (read_reg2 == pend_addr);
`endif

    // Read-port next values. Address 0 is forced to zero explicitly, so the
    // result does not depend on what regs[0] holds.
    always_comb begin
        rd1_next = '0;
        rd2_next = '0;
        if (read_reg1 != '0) begin
            rd1_next = regs[read_reg1];
        end
        if (read_reg2 != '0) begin
            rd2_next = regs[read_reg2];
        end
`ifdef WB_BYPASS_EN
        // The word being committed at this edge takes priority over the
        // stale array contents.
        if (hit1) begin
            rd1_next = write_data;
        end
        if (hit2) begin
            rd2_next = write_data;
        end
`endif
    end

    // Write pipeline and read registers. Reset also clears pend_valid, so a
    // write captured before reset never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            wb_done    <= 1'b0;
            read_data1 <= '0;
            read_data2 <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_IDX) begin
                    regs[i] <= DATA_W'(SP_RESET);
                end else begin
                    regs[i] <= '0;
                end
            end
        end else begin
            pend_valid <= reg_write;
            pend_addr  <= write_reg;
            wb_done    <= pend_valid;
            read_data1 <= rd1_next;
            read_data2 <= rd2_next;
            if (commit_en) begin
                regs[pend_addr] <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_wb
//
// The driver applies one input vector per clock, on the falling edge.
// For each vector it works out the expected outputs with a reference model
// and pushes them onto exp_q. The model is a memory array plus a queue of
// writes that are still waiting for their data.
//
// The monitor samples the DUT 1 ns after every rising edge. Each time it
// samples, it pops one expected entry and compares.
//
// Define WB_BYPASS_EN for both the bench and the RTL to check bypass mode.
// ---------------------------------------------------------------------------
module tb_reg_bank_wb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int SP_IDX   = 29;
    localparam int SP_RESET = 227;
    localparam int EXP_W    = 2 * DATA_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset      = 1'b1;
    logic              reg_write  = 1'b0;
    logic [ADDR_W-1:0] write_reg  = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic [ADDR_W-1:0] read_reg1  = '0;
    logic [ADDR_W-1:0] read_reg2  = '0;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              wb_pending;
    logic              wb_done;

    reg_bank_wb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_IDX  (SP_IDX),
        .SP_RESET(SP_RESET)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .wb_pending(wb_pending),
        .wb_done   (wb_done)
    );

    // ---------------- reference model ----------------
    // Expected outputs are packed as {read_data1, read_data2, wb_pending, wb_done}.
    logic [EXP_W-1:0]  exp_q [$];
    logic [DATA_W-1:0] mdl_mem [32];
    int                wait_q [$];   // addresses still waiting for their data
    int                vectors     = 0;
    int                miscompares = 0;

    // Read value as seen at an edge. With bypass enabled, a read of the
    // address being committed at that edge returns the word being written.
    function automatic logic [DATA_W-1:0] mdl_read(input int a, input bit com,
                                                   input int ca,
                                                   input logic [DATA_W-1:0] cd);
        if (a == 0) return '0;
`ifdef WB_BYPASS_EN
        if (com && ca == a) return cd;
`endif
        return mdl_mem[a];
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input bit rst, input bit rw, input int wr,
                         input logic [DATA_W-1:0] wd, input int r1, input int r2);
        logic [DATA_W-1:0] e1, e2;
        bit                com;
        int                ca;

        @(negedge clk);
        reset      = rst;
        reg_write  = rw;
        write_reg  = ADDR_W'(wr);
        write_data = wd;
        read_reg1  = ADDR_W'(r1);
        read_reg2  = ADDR_W'(r2);

        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mdl_mem[i] = (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
            wait_q.delete();
            exp_q.push_back({{DATA_W{1'b0}}, {DATA_W{1'b0}}, 1'b0, 1'b0});
        end else begin
            com = (wait_q.size() > 0);
            ca  = com ? wait_q.pop_front() : 0;
            e1  = mdl_read(r1, com && ca != 0, ca, wd);
            e2  = mdl_read(r2, com && ca != 0, ca, wd);
            if (com && ca != 0) mdl_mem[ca] = wd;
            if (rw) wait_q.push_back(wr);
            exp_q.push_back({e1, e2, wait_q.size() > 0, com});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {read_data1, read_data2, wb_pending, wb_done};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t rd1=%h/%h rd2=%h/%h pend=%b/%b done=%b/%b (actual/expected)",
                             vectors, $time,
                             act[EXP_W-1 -: DATA_W], e[EXP_W-1 -: DATA_W],
                             act[DATA_W+1 -: DATA_W], e[DATA_W+1 -: DATA_W],
                             act[1], e[1], act[0], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a, r1, r2;

        // Reset, then read the stack pointer and register 0.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 29, 0);
        cycle(0, 0, 0, 0, 29, 0);

        // Single write to r8; r8 is read in cycle N+2.
        cycle(0, 1, 8, 32'h0, 8, 29);
        cycle(0, 0, 0, 32'hDEADBEEF, 8, 8);
        cycle(0, 0, 0, 32'h0, 8, 0);
        cycle(0, 0, 0, 32'h0, 8, 8);

        // Back-to-back writes to r1, r2, r3.
        cycle(0, 1, 1, 32'h0,  0, 0);
        cycle(0, 1, 2, 32'h11, 1, 2);
        cycle(0, 1, 3, 32'h22, 1, 2);
        cycle(0, 0, 0, 32'h33, 2, 3);
        cycle(0, 0, 0, 32'h0,  1, 3);
        cycle(0, 0, 0, 32'h0,  2, 3);

        // Write to r0 is discarded.
        cycle(0, 1, 0, 32'h0,  0, 0);
        cycle(0, 0, 0, 32'h55, 0, 0);
        cycle(0, 0, 0, 32'h0,  0, 0);

        // Read r5 in the commit cycle of a write to r5.
        cycle(0, 1, 5, 32'h0,  5, 5);
        cycle(0, 0, 0, 32'hA5, 5, 1);
        cycle(0, 0, 0, 32'h0,  5, 5);

        // Capture a write to r29, then reset: the write is dropped.
        cycle(0, 1, 29, 32'h0,    29, 29);
        cycle(1, 0, 0,  32'h1234, 29, 29);
        cycle(0, 0, 0,  32'h1234, 29, 0);
        cycle(0, 0, 0,  32'h0,    29, 0);

        // Reset dominates a reg_write issued on the same edge.
        cycle(1, 1, 7, 32'h0,    7, 0);
        cycle(0, 0, 0, 32'h7777, 7, 0);
        cycle(0, 0, 0, 32'h0,    7, 0);

        // SP is writable after reset.
        cycle(0, 1, 29, 32'h0,   29, 0);
        cycle(0, 0, 0,  32'hBEEF, 29, 0);
        cycle(0, 0, 0,  32'h0,   29, 29);

        // Randomized traffic. Addresses are biased toward a small set so that
        // read-after-write and commit-cycle collisions happen often.
        for (int n = 0; n < 2000; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            r1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            r2 = ($urandom_range(0, 3) == 0) ? 29 : $urandom_range(0, 6);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                  a, $urandom, r1, r2);
        end

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
